// File: rtl/avalon_rr_arbiter.sv
// avalon_rr_arbiter
// Shares one Avalon-MM slave between two masters using round-robin
// arbitration. A grant is held until the slave accepts the command
// (waitrequest low). A watchdog aborts a stalled transaction after TIMEOUT
// busy cycles: the master is released with all-ones readdata and the
// sticky timeout flag is set.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   m0_* / m1_*           master ports (address, read, write, writedata in;
//                         readdata, waitrequest out)
//   s_*                   slave port (address, read, write, writedata out;
//                         readdata, waitrequest in)
//   timeout               sticky watchdog error, cleared only by reset
module avalon_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 2047
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_waitrequest,
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata,
    input  logic                  s_waitrequest,
    output logic                  timeout
);

    // Counter holds 0..TIMEOUT-1 and never needs to wrap.
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t          state, state_nxt;
    logic            last_grant, last_grant_nxt;
    logic [WD_W-1:0] wd_count, wd_nxt;
    logic            timeout_nxt;

    logic                  m0_req, m1_req;
    logic                  busy, sel1;
    logic                  cmd_rd, cmd_wr, cmd_any;
    logic                  done, abort;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [DATA_WIDTH-1:0] g_rdata;
    logic                  g_release;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // Granted-master command mux. Write wins over read when both are set;
    // a master that drops its request yields no command at all.
    always_comb begin
        busy    = (state != IDLE);
        sel1    = (state == BUSY1);
        g_addr  = sel1 ? m1_address   : m0_address;
        g_wdata = sel1 ? m1_writedata : m0_writedata;
        cmd_wr  = busy & (sel1 ? m1_write : m0_write);
        cmd_rd  = busy & (sel1 ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
        cmd_any = cmd_rd | cmd_wr;
        done    = cmd_any & ~s_waitrequest;
        abort   = cmd_any & s_waitrequest & (wd_count == WD_LAST);
    end

    // Slave side: command is withdrawn on the abort cycle so the slave
    // never sees a half-accepted access.
    always_comb begin
        s_read      = cmd_rd & ~abort;
        s_write     = cmd_wr & ~abort;
        s_address   = busy ? g_addr  : '0;
        s_writedata = busy ? g_wdata : '0;
    end

    // Master side: only the granted master is ever released.
    always_comb begin
        g_release = done | abort;
        g_rdata   = abort ? '1 : (done ? s_readdata : '0);

        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        if (state == BUSY0) begin
            m0_waitrequest = ~g_release;
            m0_readdata    = g_rdata;
        end
        if (state == BUSY1) begin
            m1_waitrequest = ~g_release;
            m1_readdata    = g_rdata;
        end
    end

    // Next state. Every BUSY exit returns to IDLE, giving the one-cycle
    // bubble in which the other master can win arbitration.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wd_nxt         = wd_count;
        timeout_nxt    = timeout | abort;
        case (state)
            IDLE: begin
                // On a tie, the master not granted last time wins.
                if (m0_req && (!m1_req || last_grant)) begin
                    state_nxt      = BUSY0;
                    last_grant_nxt = 1'b0;
                    wd_nxt         = '0;
                end else if (m1_req) begin
                    state_nxt      = BUSY1;
                    last_grant_nxt = 1'b1;
                    wd_nxt         = '0;
                end
            end
            BUSY0, BUSY1: begin
                if (!cmd_any || done || abort)
                    state_nxt = IDLE;
                else
                    wd_nxt = wd_count + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_count   <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wd_count   <= wd_nxt;
            timeout    <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Self-checking bench for avalon_rr_arbiter. A cycle-level reference model
// tracks who owns the slave (owner = -1 when free), the last winner, the
// stall counter and the sticky error; it predicts every DUT output each cycle.
module tb_avalon_rr_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 320;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wdat [2];
    logic          m_rd   [2];
    logic          m_wr   [2];
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [AW-1:0] s_address;
    logic          s_read, s_write, s_waitrequest, timeout;
    logic [DW-1:0] s_writedata, s_readdata;

    logic [DW-1:0] mem [16];
    always_comb s_readdata = mem[s_address[3:0]];

    avalon_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
        .m0_writedata(m_wdat[0]), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
        .m1_writedata(m_wdat[1]), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .timeout(timeout)
    );

    typedef struct packed {
        logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdat;
        logic w0; logic w1; logic [DW-1:0] r0; logic [DW-1:0] r1; logic to;
    } outs_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int owner, last, wd;
    bit to_flag;
    int dut_log[$];   // master index released by the DUT, in order
    int n_cycles;

    task automatic model_reset();
        owner = -1; last = 1; wd = 0; to_flag = 0;
        dut_log.delete();
    endtask

    function automatic outs_t model_out();
        outs_t e;
        logic rd, wr, done, abrt;
        logic [DW-1:0] rdat;
        int x;
        e = '0; e.w0 = 1'b1; e.w1 = 1'b1; e.to = to_flag;
        if (owner >= 0) begin
            x = owner;
            wr = m_wr[x];
            rd = m_rd[x] && !m_wr[x];
            done = (rd || wr) && !s_waitrequest;
            abrt = (rd || wr) && s_waitrequest && (wd == TO - 1);
            e.addr = m_addr[x];
            e.wdat = m_wdat[x];
            e.rd = rd && !abrt;
            e.wr = wr && !abrt;
            rdat = abrt ? '1 : mem[m_addr[x][3:0]];
            if (done || abrt) begin
                if (x == 0) begin e.w0 = 1'b0; e.r0 = rdat; end
                else        begin e.w1 = 1'b0; e.r1 = rdat; end
            end
        end
        return e;
    endfunction

    function automatic outs_t dut_out();
        return {s_read, s_write, s_address, s_writedata, m0_waitrequest,
                m1_waitrequest, m0_readdata, m1_readdata, timeout};
    endfunction

    // Advance the model, the slave memory and the clock by one cycle.
    task automatic tick();
        bit r0, r1, rq;
        if (!m0_waitrequest) dut_log.push_back(0);
        if (!m1_waitrequest) dut_log.push_back(1);
        if (s_write && !s_waitrequest) mem[s_address[3:0]] = s_writedata;
        if (owner < 0) begin
            r0 = m_rd[0] | m_wr[0];
            r1 = m_rd[1] | m_wr[1];
            if (r0 && (!r1 || last == 1)) owner = 0;
            else if (r1) owner = 1;
            if (owner >= 0) begin last = owner; wd = 0; end
        end else begin
            rq = m_rd[owner] | m_wr[owner];
            if (!rq || !s_waitrequest) owner = -1;
            else if (wd == TO - 1) begin to_flag = 1; owner = -1; end
            else wd++;
        end
        n_cycles++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_addr[i] = '0; m_wdat[i] = '0;
        end
        s_waitrequest = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        outs_t e, o;
        reset = 1;
        model_reset();
        m_rd[0] = 1; m_wr[1] = 1; m_addr[0] = 32'h9; m_addr[1] = 32'hA;
        @(posedge clk); #1;
        o = dut_out();
        e = '0; e.w0 = 1'b1; e.w1 = 1'b1;
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", o, e);
        end
        apply_reset();
    endtask

    task automatic test_single_write();
        outs_t e, o;
        apply_reset();
        m_wr[0] = 1; m_addr[0] = 32'd5; m_wdat[0] = 32'h1234; mem[5] = 32'h0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) m_wr[0] = 0;
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_write cyc=%0d got=%h exp=%h", c, o, e);
            end
            if (c == 1) begin
                checks++;
                if (s_write !== 1'b1 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
                    failures++;
                    $display("FAIL single_write_latency got s_write=%b m0_wait=%b m1_wait=%b exp 1 0 1",
                             s_write, m0_waitrequest, m1_waitrequest);
                end
            end
            tick();
        end
        checks++;
        if (mem[5] !== 32'h1234) begin
            failures++;
            $display("FAIL single_write_mem got=%h exp=00001234", mem[5]);
        end
    endtask

    task automatic test_contention();
        outs_t e, o;
        int exp_order[4] = '{0, 1, 0, 1};
        apply_reset();
        m_rd[0] = 1; m_addr[0] = 32'd1;
        m_rd[1] = 1; m_addr[1] = 32'd2;
        for (int c = 0; c < 8; c++) begin
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL contention cyc=%0d got=%h exp=%h", c, o, e);
            end
            tick();
        end
        checks++;
        if (dut_log.size() != 4) begin
            failures++;
            $display("FAIL contention_count got=%0d exp=4", dut_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dut_log[k] != exp_order[k]) begin
                    failures++;
                    $display("FAIL contention_order idx=%0d got=%0d exp=%0d", k, dut_log[k], exp_order[k]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        outs_t e, o;
        logic [DW-1:0] want;
        int waits = 0;
        apply_reset();
        mem[3] = 32'hC0DE_0003; want = 32'hC0DE_0003;
        m_rd[0] = 1; m_addr[0] = 32'd3;
        m_rd[1] = 1; m_addr[1] = 32'd8;
        for (int c = 0; c <= 301; c++) begin
            s_waitrequest = (c >= 1 && c <= 300);
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", c, o, e);
            end
            if (c >= 1 && c <= 300 && m0_waitrequest) waits++;
            if (c == 301) begin
                checks++;
                if (m0_waitrequest !== 1'b0 || m0_readdata !== want || m1_waitrequest !== 1'b1
                    || timeout !== 1'b0 || waits != 300) begin
                    failures++;
                    $display("FAIL stall_end got wait=%b data=%h m1_wait=%b to=%b stalls=%0d exp 0 %h 1 0 300",
                             m0_waitrequest, m0_readdata, m1_waitrequest, timeout, waits, want);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        outs_t e, o;
        int rel = -1;
        apply_reset();
        m_rd[1] = 1; m_addr[1] = 32'd4;
        s_waitrequest = 1;
        for (int c = 0; c < TO + 4; c++) begin
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL watchdog cyc=%0d got=%h exp=%h", c, o, e);
            end
            if (rel < 0 && m1_waitrequest === 1'b0) begin
                rel = c;
                checks++;
                if (m1_readdata !== '1 || s_read !== 1'b0) begin
                    failures++;
                    $display("FAIL watchdog_abort got data=%h s_read=%b exp ffffffff 0", m1_readdata, s_read);
                end
            end
            tick();
            if (rel >= 0) m_rd[1] = 0;
        end
        checks++;
        if (rel != TO || timeout !== 1'b1) begin
            failures++;
            $display("FAIL watchdog_cycle got rel=%0d to=%b exp rel=%0d to=1", rel, timeout, TO);
        end
        // Following transaction completes normally; error stays set.
        s_waitrequest = 0; m_wr[0] = 1; m_addr[0] = 32'd6; m_wdat[0] = 32'h5A5A;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) m_wr[0] = 0;
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL watchdog_after cyc=%0d got=%h exp=%h", c, o, e);
            end
            tick();
        end
        checks++;
        if (mem[6] !== 32'h5A5A || timeout !== 1'b1) begin
            failures++;
            $display("FAIL watchdog_sticky got mem=%h to=%b exp 00005a5a 1", mem[6], timeout);
        end
    endtask

    task automatic test_reset_mid();
        outs_t e, o;
        // Leave timeout set from the previous test; reset must clear it.
        idle_inputs();
        m_rd[1] = 1; m_addr[1] = 32'd2; s_waitrequest = 1;
        for (int c = 0; c < 3; c++) begin
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, o, e);
            end
            tick();
        end
        #1;
        reset = 1;
        model_reset();
        #1;
        checks++;
        if (s_read !== 1'b0 || m1_waitrequest !== 1'b1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got s_read=%b m1_wait=%b to=%b exp 0 1 0", s_read, m1_waitrequest, timeout);
        end
        @(posedge clk); #1;
        reset = 0;
        s_waitrequest = 0; m_rd[0] = 1; m_addr[0] = 32'd1;
        for (int c = 0; c < 4; c++) begin
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", c, o, e);
            end
            tick();
        end
        checks++;
        if (dut_log.size() < 1 || dut_log[0] != 0) begin
            failures++;
            $display("FAIL reset_mid_first got=%0d exp=0", dut_log.size() < 1 ? -1 : dut_log[0]);
        end
        idle_inputs();
    endtask

    task automatic test_read_write();
        outs_t e, o;
        apply_reset();
        m_rd[1] = 1; m_wr[1] = 1; m_addr[1] = 32'd7; m_wdat[1] = 32'hABCD; mem[7] = 32'h0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin m_rd[1] = 0; m_wr[1] = 0; end
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL read_write cyc=%0d got=%h exp=%h", c, o, e);
            end
            if (c == 1) begin
                checks++;
                if (s_write !== 1'b1 || s_read !== 1'b0) begin
                    failures++;
                    $display("FAIL read_write_cmd got wr=%b rd=%b exp 1 0", s_write, s_read);
                end
            end
            tick();
        end
        checks++;
        if (mem[7] !== 32'hABCD) begin
            failures++;
            $display("FAIL read_write_mem got=%h exp=0000abcd", mem[7]);
        end
    endtask

    task automatic test_random();
        outs_t e, o;
        bit rel [2];
        apply_reset();
        rel[0] = 0; rel[1] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rel[i] || (!m_rd[i] && !m_wr[i]) || $urandom_range(0, 19) == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        m_rd[i] = 1'($urandom); m_wr[i] = 1'($urandom);
                        m_addr[i] = 32'($urandom_range(0, 15)); m_wdat[i] = $urandom;
                    end else begin
                        m_rd[i] = 0; m_wr[i] = 0;
                    end
                end
            end
            s_waitrequest = ($urandom_range(0, 2) == 0);
            #1; e = model_out(); o = dut_out();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, o, e);
            end
            rel[0] = !m0_waitrequest;
            rel[1] = !m1_waitrequest;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_cycles = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        idle_inputs();
        model_reset();
        reset = 1;
        test_reset();
        test_single_write();
        test_contention();
        test_stall();
        test_read_write();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
